// File: rtl/tx_cb_pkg.sv
// Shared types and helpers for the TX channel-bonding datapath.
// The keep helper is also used by the RX side, so it takes a wide, zero-extended argument.
package tx_cb_pkg;

  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;

  // Widest byte-enable vector any bonding block passes to keep_is_contiguous.
  localparam int KEEP_MAX_W = 128;

  // True when keep is 0...01...1 with at least one bit set. The caller zero-extends,
  // so an all-ones value overflowing on +1 still yields zero after the AND.
  function automatic logic keep_is_contiguous(input logic [KEEP_MAX_W-1:0] keep);
    return (keep != '0) && ((keep & (keep + KEEP_MAX_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry registered AXI-Stream buffer carrying tdata/tkeep/tlast.
// The upstream ready is a flop, so no combinational path runs from out_tready_i to in_ready_o.
module axis_skid_buf #(
  parameter int DWIDTH = 480
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DWIDTH-1:0]     in_tdata_i,
  input  logic [DWIDTH/8-1:0]   in_tkeep_i,
  input  logic                  in_tlast_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  output logic [DWIDTH-1:0]     out_tdata_o,
  output logic [DWIDTH/8-1:0]   out_tkeep_o,
  output logic                  out_tlast_o,
  output logic                  out_tvalid_o,
  input  logic                  out_tready_i
);

  localparam int KW = DWIDTH / 8;
  localparam int EW = DWIDTH + KW + 1;

  logic [EW-1:0] head_q, head_d;
  logic [EW-1:0] tail_q, tail_d;
  logic [1:0]    count_q, count_d;
  logic          ready_q, ready_d;
  logic [EW-1:0] inEntry;
  logic          push;
  logic          pop;

  assign inEntry = {in_tlast_i, in_tkeep_i, in_tdata_i};
  assign push    = in_valid_i & ready_q;
  assign pop     = (count_q != 2'd0) & out_tready_i;

  // The head register always feeds the output; the tail only holds the overflow beat.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    case (count_q)
      2'd0: begin
        if (push) begin
          head_d  = inEntry;
          count_d = 2'd1;
        end
      end
      2'd1: begin
        case ({push, pop})
          2'b11: head_d = inEntry;
          2'b10: begin
            tail_d  = inEntry;
            count_d = 2'd2;
          end
          2'b01: count_d = 2'd0;
          default: count_d = count_q;
        endcase
      end
      2'd2: begin
        if (pop) begin
          head_d  = tail_q;
          count_d = 2'd1;
        end
      end
      default: count_d = 2'd0;
    endcase
    ready_d = (count_d != 2'd2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 2'd0;
      ready_q <= 1'b1;
    end else begin
      count_q <= count_d;
      ready_q <= ready_d;
    end
  end

  // Payload needs no reset: it is only observed while count_q says it is valid.
  always_ff @(posedge clk) begin
    head_q <= head_d;
    tail_q <= tail_d;
  end

  assign in_ready_o   = ready_q;
  assign out_tvalid_o = (count_q != 2'd0);
  assign {out_tlast_o, out_tkeep_o, out_tdata_o} = head_q;

endmodule

// File: rtl/tx_cb_pkt_arbiter.sv
// Packet-locked round-robin arbiter feeding the bonded TX splitter through a skid buffer.
// A grant is held from arbitration until the granted source's tlast beat is accepted.
module tx_cb_pkt_arbiter
  import tx_cb_pkg::*;
#(
  parameter  int DWIDTH = 480,
  parameter  int N_SRC  = 4,
  localparam int SRC_W  = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DWIDTH-1:0]   s_axis_tdata [N_SRC],
  input  logic [DWIDTH/8-1:0] s_axis_tkeep [N_SRC],
  input  logic [N_SRC-1:0]    s_axis_tlast,
  input  logic [N_SRC-1:0]    s_axis_tvalid,
  output logic [N_SRC-1:0]    s_axis_tready,
  output logic [DWIDTH-1:0]   m_axis_tdata,
  output logic [DWIDTH/8-1:0] m_axis_tkeep,
  output logic                m_axis_tlast,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic [SRC_W-1:0]    grant_idx,
  output logic                busy,
  output logic                keep_err
);

  arb_state_t          state_q, state_d;
  logic [SRC_W-1:0]    grant_q, grant_d;
  logic [SRC_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic                keep_err_q, keep_err_d;

  logic [DWIDTH-1:0]   selTdata;
  logic [DWIDTH/8-1:0] selTkeep;
  logic                selTlast;
  logic                selTvalid;
  logic                skidInReady;
  logic                accept;
  logic                pickValid;
  logic [SRC_W-1:0]    pickIdx;
  logic [SRC_W-1:0]    nextPtr;
  logic [KEEP_MAX_W-1:0] keepExt;
  logic                keepBad;

  // Scan from ptr upward (mod N_SRC); iterating backwards lets the nearest requester win.
  function automatic logic [SRC_W-1:0] rrPick(input logic [N_SRC-1:0] req,
                                              input logic [SRC_W-1:0] ptr);
    logic [SRC_W-1:0] pick;
    logic [SRC_W-1:0] cand;
    pick = ptr;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      cand = SRC_W'((int'(ptr) + i) % N_SRC);
      if (req[cand]) pick = cand;
    end
    return pick;
  endfunction

  assign selTdata  = s_axis_tdata[grant_q];
  assign selTkeep  = s_axis_tkeep[grant_q];
  assign selTlast  = s_axis_tlast[grant_q];
  assign selTvalid = s_axis_tvalid[grant_q];
  assign accept    = (state_q == ARB_BUSY) & selTvalid & skidInReady;

  assign pickValid = |s_axis_tvalid;
  assign pickIdx   = rrPick(s_axis_tvalid, rr_ptr_q);
  assign nextPtr   = SRC_W'((int'(grant_q) + 1) % N_SRC);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      keep_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      keep_err_q <= keep_err_d;
    end
  end

  // The arbitration cycle only latches the grant; the first beat is taken in BUSY.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      ARB_IDLE: begin
        if (pickValid) begin
          state_d = ARB_BUSY;
          grant_d = pickIdx;
        end
      end
      ARB_BUSY: begin
        if (accept && selTlast) begin
          state_d  = ARB_IDLE;
          rr_ptr_d = nextPtr;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    s_axis_tready = '0;
    if (state_q == ARB_BUSY) s_axis_tready[grant_q] = skidInReady;
    busy = (state_q == ARB_BUSY);
  end

  // Mid-packet beats must carry every byte; a last beat may be short but left-packed.
  always_comb begin
    keepExt    = KEEP_MAX_W'(selTkeep);
    keepBad    = selTlast ? !keep_is_contiguous(keepExt) : !(&selTkeep);
    keep_err_d = keep_err_q | (accept & keepBad);
  end

  assign grant_idx = grant_q;
  assign keep_err  = keep_err_q;

  axis_skid_buf #(
    .DWIDTH(DWIDTH)
  ) u_skid (
    .clk          (clk),
    .rst          (rst),
    .in_tdata_i   (selTdata),
    .in_tkeep_i   (selTkeep),
    .in_tlast_i   (selTlast),
    .in_valid_i   (accept),
    .in_ready_o   (skidInReady),
    .out_tdata_o  (m_axis_tdata),
    .out_tkeep_o  (m_axis_tkeep),
    .out_tlast_o  (m_axis_tlast),
    .out_tvalid_o (m_axis_tvalid),
    .out_tready_i (m_axis_tready)
  );

endmodule
